// File: rtl/uart_pkg.sv
// UART transmitter shared types: FSM states, parity modes, word-length encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    // Word length N = DBITS_BASE + data_bits code (00..11 -> 5..8).
    localparam logic [2:0] DBITS_BASE = 3'd5;

    localparam logic UART_IDLE_LVL = 1'b1;

    // Index of the last data bit sent for a given word-length code.
    function automatic logic [2:0] last_data_idx(input logic [1:0] code);
        return DBITS_BASE - 3'd1 + {1'b0, code};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty/full/level; rdata valid whenever non-empty.
// Latency: write visible at the output one edge after it is accepted.
// Backpressure: writes while full and reads while empty are ignored.
//   ports: wr_i/wdata_i write side, rd_i/rdata_o read side, empty_o/full_o/level_o status.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             empty_q;
    logic             full_q;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_i && !full_q;
    assign rd_ok = rd_i && !empty_q;

    always_comb begin
        level_d = level_q;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == (AW+1)'(DEPTH));
        end
    end

    assign rdata_o = mem[rptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter with runtime word length, parity and stop bits.
// Latency: a queued byte starts one edge after empty_o falls; frames run back to back.
// Backpressure: full_o; writes while full are dropped and flagged on overflow_o.
//   ports: baud_div_i/data_bits_i/parity_i/stop2_i config (latched per frame),
//   tx_we_i/din_i write side, tx_en_i start gate, empty_o/full_o/level_o/overflow_o
//   FIFO status, busy_o frame in progress, tx_bit_o registered serial line.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DIV_W-1:0]              baud_div_i,
    input  logic                          tx_en_i,
    input  logic                          tx_we_i,
    input  logic [7:0]                    din_i,
    input  logic [1:0]                    data_bits_i,
    input  logic [1:0]                    parity_i,
    input  logic                          stop2_i,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          busy_o,
    output logic                          tx_bit_o
);

    logic [7:0]       fifo_rdata;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;

    tx_state_t        state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             line_d;

    // Frame configuration captured at the pop.
    logic [DIV_W-1:0] div_q;
    logic [7:0]       data_q;
    logic [1:0]       dbits_q;
    parity_t          par_q;
    logic             stop2_q;

    logic             tx_bit_q;
    logic             ovf_q;

    logic [DIV_W-1:0] eff_div;
    logic             bit_end;
    logic             last_stop;
    logic             par_en;
    logic             frame_done;
    logic [7:0]       dmask;
    logic             par_bit;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_i    (tx_we_i),
        .wdata_i (din_i),
        .rd_i    (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (level_o)
    );

    assign eff_div    = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
    assign bit_end    = (baud_q == '0);
    assign last_stop  = (bit_q == {2'b00, stop2_q});
    assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign frame_done = (state_q == STOP) && bit_end && last_stop;
    // Popping at the end of the last stop bit gives gap-free back-to-back frames.
    assign pop        = tx_en_i && !fifo_empty && ((state_q == IDLE) || frame_done);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dmask[i] = (3'(i) <= last_data_idx(dbits_q));
        end
        par_bit = (^(data_q & dmask)) ^ (par_q == PAR_ODD);
    end

    // Next-state: every bit start reloads the baud counter with div-1.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        baud_d  = bit_end ? baud_q : baud_q - DIV_W'(1);
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    baud_d  = eff_div - DIV_W'(1);
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    baud_d  = div_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = div_q - DIV_W'(1);
                    if (bit_q == last_data_idx(dbits_q)) begin
                        state_d = par_en ? PARITY : STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = 3'd0;
                    baud_d  = div_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        if (pop) begin
                            state_d = START;
                            baud_d  = eff_div - DIV_W'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        baud_d = div_q - DIV_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx_bit_o can be a flop
    // that changes on the same edge as the state.
    always_comb begin
        line_d = UART_IDLE_LVL;
        case (state_d)
            START:   line_d = ~UART_IDLE_LVL;
            DATA:    line_d = data_q[bit_d];
            PARITY:  line_d = par_bit;
            default: line_d = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            div_q    <= DIV_W'(1);
            data_q   <= 8'h00;
            dbits_q  <= 2'b11;
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
            tx_bit_q <= UART_IDLE_LVL;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_bit_q <= line_d;
            ovf_q    <= tx_we_i && fifo_full;
            if (pop) begin
                div_q   <= eff_div;
                data_q  <= fifo_rdata;
                dbits_q <= data_bits_i;
                par_q   <= parity_t'(parity_i);
                stop2_q <= stop2_i;
            end
        end
    end

    assign empty_o    = fifo_empty;
    assign full_o     = fifo_full;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != IDLE);
    assign tx_bit_o   = tx_bit_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame shapes, FIFO flags, overflow, gating, reset.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic        tx_en = 1'b0;
    logic        tx_we = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [1:0]  data_bits = 2'b11;
    logic [1:0]  parity = 2'b00;
    logic        stop2 = 1'b0;
    logic        empty_o, full_o, overflow_o, busy_o, tx_bit_o;
    logic [4:0]  level_o;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] seq;
    int          hi;
    int          bad;

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .FIFO_DEPTH (16),
        .DIV_W      (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .baud_div_i  (baud_div),
        .tx_en_i     (tx_en),
        .tx_we_i     (tx_we),
        .din_i       (din),
        .data_bits_i (data_bits),
        .parity_i    (parity),
        .stop2_i     (stop2),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o),
        .tx_bit_o    (tx_bit_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_en = 1'b0;
        tx_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg(input logic [15:0] div, input logic [1:0] db,
                       input logic [1:0] par, input logic s2);
        baud_div  = div;
        data_bits = db;
        parity    = par;
        stop2     = s2;
    endtask

    task automatic wr(input logic [7:0] d);
        tx_we = 1'b1;
        din   = d;
        @(negedge clk);
        tx_we = 1'b0;
    endtask

    // Samples nb bit periods of div cycles from the current falling edge.
    // seq[b] is the line level at the first cycle of period b; bad counts
    // cycles where the line differs from that within the period.
    task automatic grab(input int nb, input int div, output logic [15:0] s,
                        output int busy_cnt, output int unstable);
        s = '0;
        busy_cnt = 0;
        unstable = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < div; c++) begin
                if (busy_o) busy_cnt++;
                if (c == 0) s[b] = tx_bit_o;
                else if (tx_bit_o !== s[b]) unstable++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_tx", tx_bit_o, 1);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 8N1, div 4, 0x55
        cfg(16'd4, 2'b11, 2'b00, 1'b0);
        tx_en = 1'b1;
        wr(8'h55);
        check("8n1_empty_after_wr", empty_o, 0);
        check("8n1_level_after_wr", level_o, 1);
        check("8n1_idle_before_pop", tx_bit_o, 1);
        @(negedge clk);
        check("8n1_start_low", tx_bit_o, 0);
        check("8n1_busy_rise", busy_o, 1);
        check("8n1_level_after_pop", level_o, 0);
        grab(10, 4, seq, hi, bad);
        check("8n1_seq", seq, 16'h02AA);
        check("8n1_stable", bad, 0);
        check("8n1_busy_cycles", hi, 40);
        check("8n1_busy_fall", busy_o, 0);
        check("8n1_line_idle", tx_bit_o, 1);

        // 7 data bits, even parity, 2 stop, div 2, 0x87
        cfg(16'd2, 2'b10, 2'b01, 1'b1);
        wr(8'h87);
        @(negedge clk);
        grab(11, 2, seq, hi, bad);
        check("7e2_seq", seq, 16'h070E);
        check("7e2_stable", bad, 0);
        check("7e2_busy_cycles", hi, 22);
        check("7e2_busy_fall", busy_o, 0);

        // 5 data bits, odd parity, div 0 behaves as 1, upper bits ignored
        cfg(16'd0, 2'b00, 2'b10, 1'b0);
        wr(8'hE3);
        @(negedge clk);
        grab(8, 1, seq, hi, bad);
        check("5o1_seq", seq, 16'h00C6);
        check("5o1_busy_cycles", hi, 8);
        check("5o1_busy_fall", busy_o, 0);

        // Overflow
        do_reset();
        cfg(16'd4, 2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            if (i == 14) begin
                check("ovf_full_at15", full_o, 0);
                check("ovf_level_at15", level_o, 15);
            end
        end
        check("ovf_full_at16", full_o, 1);
        check("ovf_level_at16", level_o, 16);
        check("ovf_no_pulse_yet", overflow_o, 0);
        wr(8'hEE);
        check("ovf_pulse", overflow_o, 1);
        check("ovf_level_held", level_o, 16);
        @(negedge clk);
        check("ovf_pulse_one_cycle", overflow_o, 0);
        check("ovf_level_still", level_o, 16);
        check("ovf_no_tx", busy_o, 0);

        // Back-to-back frames, div 3
        do_reset();
        cfg(16'd3, 2'b11, 2'b00, 1'b0);
        wr(8'hA5);
        wr(8'h3C);
        check("b2b_level2", level_o, 2);
        check("b2b_gated_idle", busy_o, 0);
        tx_en = 1'b1;
        @(negedge clk);
        check("b2b_start", tx_bit_o, 0);
        check("b2b_level1", level_o, 1);
        grab(10, 3, seq, hi, bad);
        check("b2b_seq1", seq, 16'h034A);
        check("b2b_busy1", hi, 30);
        grab(10, 3, seq, hi, bad);
        check("b2b_seq2", seq, 16'h0278);
        check("b2b_busy2", hi, 30);
        check("b2b_stable", bad, 0);
        check("b2b_done", busy_o, 0);
        check("b2b_empty", empty_o, 1);

        // Enable dropped during the first frame
        do_reset();
        cfg(16'd3, 2'b11, 2'b00, 1'b0);
        wr(8'h0F);
        wr(8'hF0);
        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        grab(10, 3, seq, hi, bad);
        check("gate_seq", seq, 16'h021E);
        check("gate_busy", hi, 30);
        repeat (12) @(negedge clk);
        check("gate_line_high", tx_bit_o, 1);
        check("gate_not_busy", busy_o, 0);
        check("gate_level1", level_o, 1);

        // Reset in the middle of DATA
        do_reset();
        cfg(16'd4, 2'b11, 2'b00, 1'b0);
        tx_en = 1'b1;
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        check("rmf_level_before", level_o, 2);
        repeat (6) @(negedge clk);
        check("rmf_busy_before", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rmf_tx", tx_bit_o, 1);
        check("rmf_busy", busy_o, 0);
        check("rmf_empty", empty_o, 1);
        check("rmf_full", full_o, 0);
        check("rmf_level", level_o, 0);
        check("rmf_ovf", overflow_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rmf_empty_after", empty_o, 1);
        check("rmf_idle_after", busy_o, 0);
        check("rmf_line_after", tx_bit_o, 1);

        // Mid-frame divisor change 4 -> 8
        do_reset();
        cfg(16'd4, 2'b11, 2'b00, 1'b0);
        tx_en = 1'b1;
        wr(8'h81);
        wr(8'h18);
        check("cfg_start", tx_bit_o, 0);
        baud_div = 16'd8;
        grab(10, 4, seq, hi, bad);
        check("cfg_seq1", seq, 16'h0302);
        check("cfg_busy1", hi, 40);
        check("cfg_stable1", bad, 0);
        grab(10, 8, seq, hi, bad);
        check("cfg_seq2", seq, 16'h0230);
        check("cfg_busy2", hi, 80);
        check("cfg_stable2", bad, 0);
        check("cfg_done", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, FIFO-buffered UART transmitter. It generalises the fixed 8N1 transmitter with the following:
- configurable FIFO depth;
- runtime-selectable 5–8 data bits, parity and 1/2 stop bits;
- fill-level and overflow reporting.

It sits behind a bus-side register block, with `tx_bit_o` driving the pad.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the baud divisor.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset is asynchronous and active-low.
- `baud_div_i` in `DIV_W`: clock cycles per bit; value 0 is treated as 1.
- `tx_en_i` in 1: permits starting new frames.
- `tx_we_i` in 1: write strobe for `din_i`.
- `din_i` in 8: data byte; LSB transmitted first.
- `data_bits_i` in 2: word length; 00=5, 01=6, 10=7, 11=8 data bits.
- `parity_i` in 2: 00=none, 01=even, 10=odd, 11=none.
- `stop2_i` in 1: 1 = two stop bits, 0 = one.
- `empty_o` out 1: FIFO empty.
- `full_o` out 1: FIFO full.
- `level_o` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `overflow_o` out 1: one-cycle pulse when a write is attempted while full.
- `busy_o` out 1: frame in progress (state ≠ IDLE).
- `tx_bit_o` out 1: serial line, registered, idle high.

## Operation
- **FIFO write:** a write is accepted iff `tx_we_i && !full_o`. A write while full is dropped and pulses `overflow_o` the next cycle. A pop and write in the same cycle keep `level_o` unchanged.
- **FSM states:** IDLE → START → DATA → PARITY → STOP → (START | IDLE).
- **IDLE:** when `tx_en_i && !empty_o`, pop the head entry and enter START.
- **Config latch:** `baud_div_i`, `data_bits_i`, `parity_i` and `stop2_i` are latched at the pop. Changes mid-frame have no effect on the current frame.
- **START:** line 0.
- **DATA:** N bits, LSB first. Bits of `din_i` above N are ignored.
- **PARITY:** skipped when parity is none. The parity bit is XOR of the N data bits for even parity, and its inverse for odd parity.
- **STOP:** line 1 for 1 or 2 bit periods.
- **End of last stop bit:**
  - if `tx_en_i && !empty_o`, pop and go straight to START (no idle gap);
  - otherwise go to IDLE.
- **`tx_en_i` low mid-frame:** the current frame completes; no new frame starts.
- **Bit timing:** a baud counter loads latched_div−1 at each bit start and decrements. A bit ends when the counter reaches 0. A bit counter indexes the DATA and STOP bits.
- **Reset:** asserting `rst_ni` mid-frame aborts immediately and flushes the FIFO.

## Timing
- **Reset values:** `tx_bit_o`=1, `empty_o`=1, `full_o`=0, `level_o`=0, `overflow_o`=0, `busy_o`=0, state IDLE.
- **Flag update:** `empty_o`, `full_o` and `level_o` update on the edge after the write or pop.
- **First-word latency:** a write at edge N into an empty FIFO with `tx_en_i`=1 gives `empty_o`=0 at N+1. The pop and START happen at edge N+2, where `tx_bit_o` falls and `busy_o` rises.
- **Bit period:** every bit lasts exactly latched_div cycles.
- **Frame length:** (1 + N + P + S) × latched_div cycles, where P ∈ {0,1} and S ∈ {1,2}.
- **Back-to-back frames:** the next START bit begins on the cycle immediately after the last stop-bit cycle.
- **`busy_o`:** falls on the edge that returns the FSM to IDLE.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum` for the FSM state (IDLE, START, DATA, PARITY, STOP);
  - `typedef enum` for the parity mode;
  - the data-bits encoding;
  - constant `UART_IDLE_LVL` = 1'b1.
- One sub-module, `sync_fifo`, parametrised by width (8) and depth. It provides registered `empty`, `full` and `level`, and its read data is valid whenever it is non-empty. `uart_tx_cfg` instantiates it and contains the FSM, the counters and the config latch.

## Test plan
- **Basic 8N1 frame:** `baud_div_i`=4, 8N1, write 0x55. `tx_bit_o` must be low for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles. Frame is 40 cycles, and `busy_o` is high for exactly 40 cycles.
- **Parity and stop bits:** 7 data bits, even parity, `stop2_i`=1, `baud_div_i`=2, write 0x87. Transmitted data must be 1110000, parity bit 1, then 2 stop bits; frame is 22 cycles.
- **Overflow:** `tx_en_i`=0, write 17 bytes. `full_o`=1 and `level_o`=16 after the 16th write; the 17th write pulses `overflow_o` for one cycle and `level_o` stays 16.
- **Back-to-back and enable gating:** 2 bytes queued, `tx_en_i`=1, `baud_div_i`=3. The second START must follow the first frame's stop bit with no idle cycle. With `tx_en_i` dropped during the first frame, that frame completes and the line then stays high with `level_o`=1.
- **Reset mid-frame:** assert `rst_ni` during DATA. All outputs must take their reset values asynchronously, and the FIFO reads empty after release.
- **Mid-frame config change:** change `baud_div_i` from 4 to 8 during a frame. The current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
